g3f_io_sequencer: RTL and testbench

//  Pin-level command sequencer for the tt_um_g3f core.
//  - Collects operand bytes from the shared uio bus, strobed by ui_in.
//  - Pulses the core start, then waits for core done.
//  - Drives the result bytes back out on the same uio pins, turning the bus around safely.
//  - Owns uio_oe: it alone decides when the bidirectional pins are driven.

---
 rtl/g3f_io_sequencer.sv | 171 +++++++++++++++++
 tb/tb_g3f_io_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/g3f_io_sequencer.sv
// g3f_io_sequencer
// Pin-level command sequencer for the tt_um_g3f core. It gathers operand
// bytes from the shared uio bus on rising edges of a strobe, fires a single
// start pulse at the core, and waits (bounded by TIMEOUT) for core completion.
// It then turns the bus around and drains the result bytes back out on the
// same pins. Both directions are little-endian (byte 0 first). This block is
// the sole owner of uio_oe, so the pins are only ever driven in DRAIN.
module g3f_io_sequencer #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     strobe,
    input  logic [7:0]               bus_in,
    output logic [7:0]               bus_out,
    output logic [7:0]               bus_oe,
    output logic [8*IN_BYTES-1:0]    core_operand,
    output logic                     core_start,
    input  logic                     core_done,
    input  logic [8*OUT_BYTES-1:0]   core_result,
    output logic                     busy,
    output logic                     rdy,
    output logic                     err
);

    // One counter indexes operand bytes while loading and result bytes while
    // draining, so it is sized for the larger of the two transfers.
    localparam int MAX_BYTES = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
    localparam int CNT_W     = (MAX_BYTES < 2) ? 1 : $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(IN_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_OUT  = CNT_W'(OUT_BYTES - 1);
    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                  state_q,    state_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic                    strb_q,     strb_d;
    logic [8*IN_BYTES-1:0]   operand_q,  operand_d;
    logic [8*OUT_BYTES-1:0]  result_q,   result_d;
    logic                    err_q,      err_d;
    logic [7:0]              bus_out_q,  bus_out_d;
    logic [7:0]              bus_oe_q,   bus_oe_d;

    logic                    strb_edge;
    logic [CNT_W-1:0]        next_cnt;

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        strb_d     = strobe;
        operand_d  = operand_q;
        result_d   = result_q;
        err_d      = err_q;
        bus_out_d  = bus_out_q;
        bus_oe_d   = bus_oe_q;

        strb_edge  = strobe & ~strb_q & ena;
        next_cnt   = byte_cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (strb_edge) begin
                    operand_d[7:0] = bus_in;
                    byte_cnt_d     = CNT_W'(1);
                    err_d          = 1'b0;
                    state_d        = (IN_BYTES == 1) ? ST_START : ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (strb_edge) begin
                    operand_d[8*int'(byte_cnt_q) +: 8] = bus_in;
                    byte_cnt_d = next_cnt;
                    if (byte_cnt_q == LAST_IN) begin
                        state_d = ST_START;
                    end
                end
            end

            ST_START: begin
                wait_cnt_d = 8'd0;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                if (core_done) begin
                    result_d   = core_result;
                    bus_oe_d   = 8'hFF;
                    bus_out_d  = core_result[7:0];
                    byte_cnt_d = '0;
                    state_d    = ST_DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_DRAIN: begin
                if (strb_edge) begin
                    if (byte_cnt_q == LAST_OUT) begin
                        bus_oe_d  = 8'h00;
                        bus_out_d = 8'h00;
                        state_d   = ST_IDLE;
                    end else begin
                        byte_cnt_d = next_cnt;
                        bus_out_d  = result_q[8*int'(next_cnt) +: 8];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; the strobe history always tracks the pin, everything else freezes while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            wait_cnt_q <= 8'd0;
            strb_q     <= 1'b0;
            operand_q  <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            bus_out_q  <= 8'h00;
            bus_oe_q   <= 8'h00;
        end else begin
            strb_q <= strb_d;
            if (ena) begin
                state_q    <= state_d;
                byte_cnt_q <= byte_cnt_d;
                wait_cnt_q <= wait_cnt_d;
                operand_q  <= operand_d;
                result_q   <= result_d;
                err_q      <= err_d;
                bus_out_q  <= bus_out_d;
                bus_oe_q   <= bus_oe_d;
            end
        end
    end

    // Status and handshake outputs decoded straight from the current state.
    always_comb begin
        core_start   = (state_q == ST_START);
        busy         = (state_q == ST_START) || (state_q == ST_WAIT);
        rdy          = (state_q == ST_DRAIN);
        err          = err_q;
        bus_out      = bus_out_q;
        bus_oe       = bus_oe_q;
        core_operand = operand_q;
    end

endmodule

// File: tb/tb_g3f_io_sequencer.sv
// tb_g3f_io_sequencer
// Directed bench for the uio command sequencer: reset, a full load/start/
// wait/drain transaction, WAIT timeout with err recovery, an ena freeze in
// the middle of a load, and a reset while the bus is being driven.
module tb_g3f_io_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        strobe;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic [7:0]  bus_oe;
    logic [31:0] core_operand;
    logic        core_start;
    logic        core_done;
    logic [31:0] core_result;
    logic        busy;
    logic        rdy;
    logic        err;

    int checkCount;
    int errorCount;

    g3f_io_sequencer #(
        .IN_BYTES  (4),
        .OUT_BYTES (4),
        .TIMEOUT   (255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .strobe       (strobe),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .core_operand (core_operand),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_result  (core_result),
        .busy         (busy),
        .rdy          (rdy),
        .err          (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One full strobe pulse carrying a byte: rising edge sampled, then released.
    task automatic applyStimulus(input logic [7:0] value);
        strobe = 1'b1;
        bus_in = value;
        tick();
        strobe = 1'b0;
        tick();
    endtask

    // Main directed sequence.
    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rst_n       = 1'b0;
        ena         = 1'b1;
        strobe      = 1'b0;
        bus_in      = 8'h00;
        core_done   = 1'b0;
        core_result = 32'h0;

        // Reset held for two cycles.
        tick();
        tick();
        checkOutput("rst_bus_oe", 32'(bus_oe), 32'h00);
        checkOutput("rst_bus_out", 32'(bus_out), 32'h00);
        checkOutput("rst_core_start", 32'(core_start), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rdy", 32'(rdy), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_operand", core_operand, 32'h0);
        rst_n = 1'b1;
        tick();

        // Load 11,22,33,44.
        applyStimulus(8'h11);
        checkOutput("load1_oe", 32'(bus_oe), 32'h00);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        strobe = 1'b1;
        bus_in = 8'h44;
        tick();
        checkOutput("operand_full", core_operand, 32'h44332211);
        checkOutput("start_pulse", 32'(core_start), 32'h1);
        checkOutput("start_busy", 32'(busy), 32'h1);
        strobe = 1'b0;
        tick();
        checkOutput("start_dropped", 32'(core_start), 32'h0);
        checkOutput("wait_busy", 32'(busy), 32'h1);

        // core_done presented on WAIT cycle 3.
        tick();
        tick();
        tick();
        core_done   = 1'b1;
        core_result = 32'hDDCCBBAA;
        tick();
        core_done   = 1'b0;
        core_result = 32'h0;
        checkOutput("drain_oe", 32'(bus_oe), 32'hFF);
        checkOutput("drain_byte0", 32'(bus_out), 32'hAA);
        checkOutput("drain_rdy", 32'(rdy), 32'h1);
        checkOutput("drain_busy", 32'(busy), 32'h0);

        // Step through the result bytes.
        applyStimulus(8'h5A);
        checkOutput("drain_byte1", 32'(bus_out), 32'hBB);
        applyStimulus(8'h5A);
        checkOutput("drain_byte2", 32'(bus_out), 32'hCC);
        applyStimulus(8'h5A);
        checkOutput("drain_byte3", 32'(bus_out), 32'hDD);
        checkOutput("drain_byte3_oe", 32'(bus_oe), 32'hFF);
        strobe = 1'b1;
        bus_in = 8'h99;
        tick();
        checkOutput("drain_end_oe", 32'(bus_oe), 32'h00);
        checkOutput("drain_end_out", 32'(bus_out), 32'h00);
        checkOutput("drain_end_rdy", 32'(rdy), 32'h0);
        checkOutput("drain_end_operand", core_operand, 32'h44332211);
        strobe = 1'b0;
        tick();

        // Timeout: core_done never arrives.
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        for (int i = 0; i < 254; i++) begin
            tick();
        end
        checkOutput("timeout_not_yet", 32'(err), 32'h0);
        checkOutput("timeout_still_busy", 32'(busy), 32'h1);
        tick();
        checkOutput("timeout_err", 32'(err), 32'h1);
        checkOutput("timeout_idle", 32'(busy), 32'h0);
        checkOutput("timeout_oe", 32'(bus_oe), 32'h00);

        // New first edge clears err.
        applyStimulus(8'h55);
        checkOutput("err_cleared", 32'(err), 32'h0);
        applyStimulus(8'h66);
        checkOutput("partial_operand", core_operand, 32'h04036655);

        // Freeze with strobe toggling.
        ena = 1'b0;
        bus_in = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            strobe = ~strobe;
            tick();
        end
        strobe = 1'b0;
        tick();
        ena = 1'b1;
        checkOutput("freeze_operand", core_operand, 32'h04036655);
        checkOutput("freeze_busy", 32'(busy), 32'h0);
        applyStimulus(8'h77);
        strobe = 1'b1;
        bus_in = 8'h88;
        tick();
        checkOutput("resume_operand", core_operand, 32'h88776655);
        checkOutput("resume_start", 32'(core_start), 32'h1);
        strobe = 1'b0;
        tick();

        // Immediate done on WAIT cycle 0, then reset while driving the bus.
        core_done   = 1'b1;
        core_result = 32'h12345678;
        tick();
        core_done   = 1'b0;
        core_result = 32'h0;
        checkOutput("k0_byte0", 32'(bus_out), 32'h78);
        checkOutput("k0_oe", 32'(bus_oe), 32'hFF);
        applyStimulus(8'h00);
        checkOutput("k0_byte1", 32'(bus_out), 32'h56);
        rst_n = 1'b0;
        tick();
        checkOutput("rst_drain_oe", 32'(bus_oe), 32'h00);
        checkOutput("rst_drain_out", 32'(bus_out), 32'h00);
        checkOutput("rst_drain_rdy", 32'(rdy), 32'h0);
        checkOutput("rst_drain_operand", core_operand, 32'h0);
        rst_n = 1'b1;
        tick();

        // Spurious core_done in IDLE must not move the sequencer.
        core_done   = 1'b1;
        core_result = 32'hCAFEF00D;
        tick();
        tick();
        core_done   = 1'b0;
        checkOutput("spurious_busy", 32'(busy), 32'h0);
        checkOutput("spurious_rdy", 32'(rdy), 32'h0);
        checkOutput("spurious_oe", 32'(bus_oe), 32'h00);
        checkOutput("spurious_out", 32'(bus_out), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
